// File: rtl/pid_suma_pwm.sv
// pid_suma_pwm
//   Last stage of the PID datapath. When etapa3 strobes, the block adds the
//   P, I and D terms. It then shifts the sum right arithmetically and
//   saturates it into a PWM_BITS-wide shadow duty. A free-running PWM
//   counter copies the shadow duty into the live duty only at the period
//   wrap, so the output never glitches in the middle of a period.
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   etapa3  : one-cycle load strobe; samples Psal/Isal/Dsal
//   Psal    : proportional term, two's complement
//   Isal    : integral term, two's complement
//   Dsal    : derivative term, two's complement
//   duty    : duty value currently applied to the PWM
//   pwm     : registered PWM output
//   listo   : one-cycle pulse after each load
//   sat_hi  : last load clipped at the maximum duty
//   sat_lo  : last load clipped at zero
module pid_suma_pwm #(
  parameter int ANCHO_IN = 18,
  parameter int SHIFT    = 4,
  parameter int PWM_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                etapa3,
  input  logic [ANCHO_IN-1:0] Psal,
  input  logic [ANCHO_IN-1:0] Isal,
  input  logic [ANCHO_IN-1:0] Dsal,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm,
  output logic                listo,
  output logic                sat_hi,
  output logic                sat_lo
);

  // Two guard bits are enough for a sum of three terms, so the sum never
  // overflows.
  localparam int W = ANCHO_IN + 2;
  // The counter runs 0 .. 2^PWM_BITS-2. The period is therefore
  // 2^PWM_BITS-1 clocks, which lets a full-scale duty keep pwm high all the time.
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic signed [W-1:0]   sum_c, scaled_c, dmax_c;
  logic [PWM_BITS-1:0]   shadow_d;
  logic                  hi_d, lo_d;

  logic [PWM_BITS-1:0]   shadow_q, cnt_q, duty_q;
  logic                  pwm_q, listo_q, sat_hi_q, sat_lo_q;

  always_comb begin
    sum_c    = $signed({{2{Psal[ANCHO_IN-1]}}, Psal})
             + $signed({{2{Isal[ANCHO_IN-1]}}, Isal})
             + $signed({{2{Dsal[ANCHO_IN-1]}}, Dsal});
    scaled_c = sum_c >>> SHIFT;
    dmax_c   = {{(W-PWM_BITS){1'b0}}, {PWM_BITS{1'b1}}};
    shadow_d = scaled_c[PWM_BITS-1:0];
    hi_d     = 1'b0;
    lo_d     = 1'b0;
    if (scaled_c < 0) begin
      shadow_d = '0;
      lo_d     = 1'b1;
    end else if (scaled_c > dmax_c) begin
      shadow_d = '1;
      hi_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      listo_q  <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      listo_q <= etapa3;
      if (etapa3) begin
        shadow_q <= shadow_d;
        sat_hi_q <= hi_d;
        sat_lo_q <= lo_d;
      end
      // At the wrap, duty takes the shadow value from before this edge. A
      // load on the same edge therefore shows up one period later.
      if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        duty_q <= shadow_q;
      end else begin
        cnt_q <= cnt_q + PWM_BITS'(1);
      end
      pwm_q <= (cnt_q < duty_q);
    end
  end

  assign duty   = duty_q;
  assign pwm    = pwm_q;
  assign listo  = listo_q;
  assign sat_hi = sat_hi_q;
  assign sat_lo = sat_lo_q;

endmodule

// File: tb/tb_pid_suma_pwm.sv
// Self-checking bench for pid_suma_pwm: table of load vectors plus directed
// sequences for the wrap collision and asynchronous reset.
module tb_pid_suma_pwm;

  localparam int PER = 511;

  logic        clk, rst, etapa3;
  logic [17:0] Psal, Isal, Dsal;
  logic [8:0]  duty;
  logic        pwm, listo, sat_hi, sat_lo;

  int checks = 0;
  int errors = 0;

  pid_suma_pwm dut (
    .clk(clk), .rst(rst), .etapa3(etapa3),
    .Psal(Psal), .Isal(Isal), .Dsal(Dsal),
    .duty(duty), .pwm(pwm), .listo(listo),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] p, i, d;
    int          exp_duty;
    bit          exp_hi, exp_lo;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse etapa3 for one edge; returns on the sample right after that edge.
  task automatic load(input logic [17:0] p, input logic [17:0] i, input logic [17:0] d);
    Psal = p; Isal = i; Dsal = d; etapa3 = 1'b1;
    step();
    etapa3 = 1'b0;
  endtask

  // Advance until the sample right after a wrap edge (cnt back to 0).
  task automatic wait_wrap();
    bit seen = 0;
    for (int k = 0; k < PER + 20; k++) begin
      step();
      if (dut.cnt_q == 9'd0) begin seen = 1; break; end
    end
    if (!seen) chk("wrap_timeout", 0, 1);
  endtask

  // Count pwm high samples over one full period starting at a wrap sample.
  task automatic count_period(output int hi);
    hi = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      if (pwm) hi++;
    end
  endtask

  int hc;

  initial begin
    vt[0] = '{18'd256,    18'd512,    18'd0,      48,  0, 0}; // nominal
    vt[1] = '{18'h3FC00,  18'd0,      18'd0,      0,   0, 1}; // -1024 -> -64
    vt[2] = '{18'h1FFFF,  18'h1FFFF,  18'h1FFFF,  511, 1, 0}; // 24575 clip
    vt[3] = '{18'h3FFFF,  18'd0,      18'd0,      0,   0, 1}; // -1 >>> 4 = -1
    vt[4] = '{18'd15,     18'd0,      18'd0,      0,   0, 0}; // 15 >>> 4 = 0
    vt[5] = '{18'd8176,   18'd0,      18'd0,      511, 0, 0}; // exactly max
    vt[6] = '{18'd8000,   18'd100,    18'd92,     511, 1, 0}; // 8192 -> 512
    vt[7] = '{18'd100,    18'h3FFEC,  18'd7,      5,   0, 0}; // 87 -> 5
    vt[8] = '{18'h20000,  18'h1FFFF,  18'h1FFFF,  511, 1, 0}; // 131070 -> 8191
    vt[9] = '{18'h20000,  18'h20000,  18'h20000,  0,   0, 1}; // most negative

    rst = 1'b1; etapa3 = 1'b0; Psal = '0; Isal = '0; Dsal = '0;
    repeat (3) step();
    chk("rst_duty", duty, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_listo", listo, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    rst = 1'b0;
    repeat (2) step();

    foreach (vt[n]) begin
      load(vt[n].p, vt[n].i, vt[n].d);
      chk($sformatf("v%0d_listo1", n), listo, 1);
      chk($sformatf("v%0d_sat_hi", n), sat_hi, vt[n].exp_hi);
      chk($sformatf("v%0d_sat_lo", n), sat_lo, vt[n].exp_lo);
      step();
      chk($sformatf("v%0d_listo0", n), listo, 0);
      wait_wrap();
      chk($sformatf("v%0d_duty", n), duty, vt[n].exp_duty);
      count_period(hc);
      chk($sformatf("v%0d_pwm_hi", n), hc, vt[n].exp_duty);
    end

    // Back-to-back strobes give back-to-back listo pulses.
    load(18'd16, 18'd0, 18'd0);
    chk("b2b_listo_a", listo, 1);
    load(18'd768, 18'd0, 18'd0);
    chk("b2b_listo_b", listo, 1);
    step();
    chk("b2b_listo_end", listo, 0);
    wait_wrap();
    chk("b2b_duty", duty, 48);

    // Collision: the load lands exactly on the wrap edge.
    begin : collide
      bit seen = 0;
      for (int k = 0; k < PER + 20; k++) begin
        step();
        if (dut.cnt_q == 9'd510) begin seen = 1; break; end
      end
      if (!seen) chk("cnt510_timeout", 0, 1);
    end
    load(18'd1600, 18'd0, 18'd0);
    chk("col_cnt0", dut.cnt_q, 0);
    chk("col_duty_old", duty, 48);
    chk("col_listo", listo, 1);
    count_period(hc);
    chk("col_pwm_old", hc, 48);
    chk("col_duty_new", duty, 100);
    count_period(hc);
    chk("col_pwm_new", hc, 100);

    // Asynchronous reset in the middle of a period, with every output nonzero.
    load(18'd3200, 18'd0, 18'd0);
    wait_wrap();
    chk("pre_rst_duty", duty, 200);
    repeat (100) step();
    load(18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
    chk("pre_rst_pwm", pwm, 1);
    chk("pre_rst_sat_hi", sat_hi, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_pwm", pwm, 0);
    chk("arst_listo", listo, 0);
    chk("arst_sat_hi", sat_hi, 0);
    chk("arst_sat_lo", sat_lo, 0);
    chk("arst_cnt", dut.cnt_q, 0);
    // A strobe while reset is held must be ignored.
    step();
    load(18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
    chk("rst_ign_listo", listo, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_listo", listo, 0);
    chk("post_rst_sat_hi", sat_hi, 0);
    wait_wrap();
    chk("post_rst_duty", duty, 0);
    count_period(hc);
    chk("post_rst_pwm_hi", hc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
